// File: rtl/sequence_gen_n.sv
// -----------------------------------------------------------------------------
// sequence_gen_n
//
// Iterative multi-mode sequence generator. Computes the Nth term of a
// Fibonacci, triangle or square sequence seeded by data_in. It performs one
// WIDTH-bit add per clock. The result is returned on data_out together with a
// one-cycle done pulse.
//
// Parameters
//   WIDTH    datapath / data_in / data_out width (>= 4)
//   ORDER_W  width of the order input and of the internal iteration counter
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, wins over every other input
//   mode      in   00 fib, 01 triangle, 10 square, 11 reserved (error)
//   load      in   must be high on two consecutive cycles to start a run
//   clear     in   leaves ERROR / OVRFLOW, aborts COMPUTE
//   order     in   N, 1-based index of the term to compute
//   data_in   in   seed value
//   busy      out  high while in LOAD or COMPUTE
//   done      out  one-cycle pulse, data_out valid
//   data_out  out  result in DONE, all ones in OVRFLOW, zero otherwise
//   overflow  out  high while in OVRFLOW
//   error     out  high while in ERROR
//
// Configuration macro
//   SEQ_GEN_SATURATE_EN  when defined, a carry-out ends the run in DONE. That
//                        cycle has data_out all ones and both done and
//                        overflow high. There is no sticky OVRFLOW state.
//                        When undefined, a carry-out parks the block in
//                        OVRFLOW until clear is asserted.
// -----------------------------------------------------------------------------
module sequence_gen_n #(
    parameter int WIDTH   = 64,
    parameter int ORDER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic               clear,
    input  logic [ORDER_W-1:0] order,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out,
    output logic               overflow,
    output logic               error
);

    localparam logic [1:0] MODE_FIB = 2'b00;
    localparam logic [1:0] MODE_TRI = 2'b01;
    localparam logic [1:0] MODE_SQ  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // The addend (k or 2k-1) is formed wide enough that it can never wrap.
    // Any bit above WIDTH is then treated as an overflow.
    localparam int AW = (ORDER_W + 1 > WIDTH) ? (ORDER_W + 1) : WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4,
        ST_OVRFLOW = 3'd5
    } state_t;

    state_t             state_r;
    state_t             next_state_s;

    // Operands captured on the first load cycle
    logic [1:0]         mode_r;
    logic [ORDER_W-1:0] order_r;
    logic [WIDTH-1:0]   seed_r;

    // Iteration state
    logic [ORDER_W-1:0] k_r;
    logic [ORDER_W-1:0] steps_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;

    // Registered outputs
    logic               busy_r;
    logic               done_r;
    logic               overflow_r;
    logic               error_r;
    logic [WIDTH-1:0]   data_out_r;

    // Combinational datapath
    logic               is_fib_s;
    logic               fib_short_s;
    logic               load_bad_s;
    logic [ORDER_W-1:0] steps_init_s;
    logic [AW-1:0]      k_ext_s;
    logic [AW-1:0]      addend_wide_s;
    logic               addend_ovf_s;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH-1:0]   add_x_s;
    logic [WIDTH-1:0]   add_y_s;
    logic               carry_s;
    logic [WIDTH-1:0]   sum_s;
    logic               step_ovf_s;
    logic               last_step_s;
    logic [WIDTH-1:0]   result_s;
`ifdef SEQ_GEN_SATURATE_EN
    logic               sat_ovf_s;
`endif

    // Datapath: addend generation, the single adder, and the step/overflow decode
    always_comb begin
        is_fib_s    = (mode_r == MODE_FIB);
        // Fib terms 1 and 2 are the seed itself; one idle COMPUTE cycle, no add.
        fib_short_s = is_fib_s && (order_r <= ORDER_W'(2));
        load_bad_s  = (order_r == {ORDER_W{1'b0}}) || (mode_r == MODE_RSV) ||
                      (is_fib_s && (seed_r == {WIDTH{1'b0}}));

        if (fib_short_s) begin
            steps_init_s = ORDER_W'(1);
        end else if (is_fib_s) begin
            steps_init_s = order_r - ORDER_W'(2);
        end else begin
            steps_init_s = order_r;
        end

        k_ext_s = AW'(k_r);
        case (mode_r)
            MODE_SQ:  addend_wide_s = {k_ext_s[AW-2:0], 1'b0} - AW'(1);
            MODE_TRI: addend_wide_s = k_ext_s;
            default:  addend_wide_s = k_ext_s;
        endcase
        addend_ovf_s = ((addend_wide_s >> WIDTH) != {AW{1'b0}});
        addend_s     = addend_wide_s[WIDTH-1:0];

        if (is_fib_s) begin
            add_x_s = a_r;
            add_y_s = b_r;
        end else begin
            add_x_s = b_r;
            add_y_s = addend_s;
        end
        {carry_s, sum_s} = {1'b0, add_x_s} + {1'b0, add_y_s};

        if (fib_short_s) begin
            step_ovf_s = 1'b0;
        end else if (is_fib_s) begin
            step_ovf_s = carry_s;
        end else begin
            step_ovf_s = carry_s | addend_ovf_s;
        end

        last_step_s = (k_r == steps_r);
        result_s    = fib_short_s ? b_r : sum_s;
    end

`ifdef SEQ_GEN_SATURATE_EN
    // Saturating completion: carry-out on a step that clear did not override
    assign sat_ovf_s = (state_r == ST_COMPUTE) && !clear && step_ovf_s;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!load) begin
                    next_state_s = ST_IDLE;
                end else if (load_bad_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                // clear outranks both completion and overflow in the same cycle
                if (clear) begin
                    next_state_s = ST_IDLE;
                end else if (step_ovf_s) begin
`ifdef SEQ_GEN_SATURATE_EN
                    next_state_s = ST_DONE;
`else
                    next_state_s = ST_OVRFLOW;
`endif
                end else if (last_step_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            ST_ERROR: begin
                if (clear) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ERROR;
                end
            end
            ST_OVRFLOW: begin
                if (clear) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_OVRFLOW;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture and per-step iteration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r  <= 2'b00;
            order_r <= {ORDER_W{1'b0}};
            seed_r  <= {WIDTH{1'b0}};
            k_r     <= {ORDER_W{1'b0}};
            steps_r <= {ORDER_W{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        mode_r  <= mode;
                        order_r <= order;
                        seed_r  <= data_in;
                    end
                end
                ST_LOAD: begin
                    a_r     <= seed_r;
                    b_r     <= seed_r;
                    k_r     <= ORDER_W'(1);
                    steps_r <= steps_init_s;
                end
                ST_COMPUTE: begin
                    if (!fib_short_s) begin
                        if (is_fib_s) begin
                            a_r <= b_r;
                        end
                        b_r <= sum_s;
                    end
                    k_r <= k_r + ORDER_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            error_r    <= 1'b0;
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            busy_r  <= (next_state_s == ST_LOAD) || (next_state_s == ST_COMPUTE);
            done_r  <= (next_state_s == ST_DONE);
            error_r <= (next_state_s == ST_ERROR);
`ifdef SEQ_GEN_SATURATE_EN
            overflow_r <= sat_ovf_s;
`else
            overflow_r <= (next_state_s == ST_OVRFLOW);
`endif
            case (next_state_s)
                ST_DONE: begin
`ifdef SEQ_GEN_SATURATE_EN
                    data_out_r <= sat_ovf_s ? {WIDTH{1'b1}} : result_s;
`else
                    data_out_r <= result_s;
`endif
                end
                ST_OVRFLOW: data_out_r <= {WIDTH{1'b1}};
                default:    data_out_r <= {WIDTH{1'b0}};
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign error    = error_r;
    assign data_out = data_out_r;

endmodule

// File: tb/tb_sequence_gen_n.sv
// -----------------------------------------------------------------------------
// tb_sequence_gen_n
//
// Directed bench for sequence_gen_n, built with WIDTH=8 so that overflow
// boundaries can be reached quickly. Expected values are hand-computed.
// Cycle 0 is the cycle in which load is first seen high.
// -----------------------------------------------------------------------------
module tb_sequence_gen_n;

    localparam int WIDTH   = 8;
    localparam int ORDER_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         mode;
    logic               load;
    logic               clear;
    logic [ORDER_W-1:0] order;
    logic [WIDTH-1:0]   data_in;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   data_out;
    logic               overflow;
    logic               error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    sequence_gen_n #(.WIDTH(WIDTH), .ORDER_W(ORDER_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .load     (load),
        .clear    (clear),
        .order    (order),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .overflow (overflow),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},     {63'd0, busy},     64'd0);
        check({tag, " done"},     {63'd0, done},     64'd0);
        check({tag, " overflow"}, {63'd0, overflow}, 64'd0);
        check({tag, " error"},    {63'd0, error},    64'd0);
        check({tag, " data_out"}, {56'd0, data_out}, 64'd0);
    endtask

    // Load held two cycles; afterwards the inputs are scrambled so the run
    // can only succeed if the captured operands are used.
    task automatic start_run(input logic [1:0] m, input logic [15:0] n, input logic [7:0] d);
        mode    = m;
        order   = n;
        data_in = d;
        load    = 1'b1;
        tick();
        load    = 1'b1;
        tick();
        load    = 1'b0;
        mode    = 2'b11;
        order   = 16'd0;
        data_in = 8'd0;
        cyc     = 2;
    endtask

    task automatic wait_end();
        while (done !== 1'b1 && overflow !== 1'b1 && error !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_ok(input string tag, input logic [1:0] m, input logic [15:0] n,
                          input logic [7:0] d, input int exp_cyc, input logic [7:0] exp_val);
        start_run(m, n, d);
        wait_end();
        check({tag, " cycle"},    64'(cyc),          64'(exp_cyc));
        check({tag, " done"},     {63'd0, done},     64'd1);
        check({tag, " data_out"}, {56'd0, data_out}, {56'd0, exp_val});
        check({tag, " overflow"}, {63'd0, overflow}, 64'd0);
        tick();
        check_idle({tag, " after"});
    endtask

    task automatic run_ovf(input string tag, input logic [1:0] m, input logic [15:0] n,
                           input logic [7:0] d, input int exp_cyc);
        start_run(m, n, d);
        wait_end();
        check({tag, " cycle"},    64'(cyc),          64'(exp_cyc));
        check({tag, " overflow"}, {63'd0, overflow}, 64'd1);
        check({tag, " data_out"}, {56'd0, data_out}, 64'hFF);
`ifdef SEQ_GEN_SATURATE_EN
        check({tag, " done"}, {63'd0, done}, 64'd1);
        tick();
        check_idle({tag, " after"});
`else
        check({tag, " done"}, {63'd0, done}, 64'd0);
        tick();
        tick();
        check({tag, " sticky ovf"},  {63'd0, overflow}, 64'd1);
        check({tag, " sticky data"}, {56'd0, data_out}, 64'hFF);
        check({tag, " sticky done"}, {63'd0, done},     64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_idle({tag, " cleared"});
`endif
    endtask

    task automatic run_err(input string tag, input logic [1:0] m, input logic [15:0] n,
                           input logic [7:0] d);
        start_run(m, n, d);
        check({tag, " error"},    {63'd0, error},    64'd1);
        check({tag, " data_out"}, {56'd0, data_out}, 64'd0);
        check({tag, " busy"},     {63'd0, busy},     64'd0);
        tick();
        tick();
        check({tag, " held"},     {63'd0, error},    64'd1);
        // clear together with load: only the clear takes effect
        clear = 1'b1;
        load  = 1'b1;
        tick();
        clear = 1'b0;
        load  = 1'b0;
        check_idle({tag, " cleared"});
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        clear   = 1'b0;
        mode    = 2'b00;
        order   = 16'd0;
        data_in = 8'd0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post reset");

        // Normal runs
        run_ok("fib10",  2'b00, 16'd10, 8'd1, 10, 8'd55);
        run_ok("tri4",   2'b01, 16'd4,  8'd0, 6,  8'd10);
        run_ok("sq5",    2'b10, 16'd5,  8'd3, 7,  8'd28);
        run_ok("fib2",   2'b00, 16'd2,  8'd7, 3,  8'd7);
        run_ok("fib1",   2'b00, 16'd1,  8'd5, 3,  8'd5);
        run_ok("fib7s2", 2'b00, 16'd7,  8'd2, 7,  8'd26);
        run_ok("fib13",  2'b00, 16'd13, 8'd1, 13, 8'd233);
        run_ok("tri1",   2'b01, 16'd1,  8'd0, 3,  8'd1);
        run_ok("tri1max",2'b01, 16'd1,  8'd254, 3, 8'd255);
        run_ok("sq3",    2'b10, 16'd3,  8'd0, 5,  8'd9);
        run_ok("sq15",   2'b10, 16'd15, 8'd0, 17, 8'd225);

        // Error cases
        run_err("err order0", 2'b01, 16'd0, 8'd4);
        run_err("err mode11", 2'b11, 16'd3, 8'd1);
        run_err("err fibseed0", 2'b00, 16'd5, 8'd0);
        run_ok("after err", 2'b10, 16'd4, 8'd0, 6, 8'd16);

        // Overflow cases
        run_ovf("ovf tri30", 2'b01, 16'd30, 8'd0, 25);
        run_ovf("ovf sq16",  2'b10, 16'd16, 8'd0, 18);
        run_ovf("ovf fib14", 2'b00, 16'd14, 8'd1, 14);
        run_ovf("ovf tri1",  2'b01, 16'd1,  8'd255, 3);

        // load for a single cycle only: abort back to IDLE
        mode    = 2'b01;
        order   = 16'd3;
        data_in = 8'd0;
        load    = 1'b1;
        tick();
        check("short load busy", {63'd0, busy}, 64'd1);
        load = 1'b0;
        tick();
        check_idle("short load");
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check_idle("short load later");

        // Reset mid-COMPUTE
        start_run(2'b00, 16'd10, 8'd1);
        tick();
        check("pre reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        check_idle("mid reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check_idle("after mid reset");

        // clear mid-COMPUTE on a long fib run
        start_run(2'b00, 16'd50, 8'd1);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_idle("clear compute");
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check_idle("clear compute later");

        // Still healthy afterwards
        run_ok("final tri", 2'b01, 16'd5, 8'd2, 7, 8'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
